// File: rtl/fwpayload_pkg.sv
// ============================================================================
// Module  : fwpayload_pkg
// Purpose : Shared register offsets, default pad count and byte-lane helper
//           for the firmware-payload GPIO block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fwpayload_pkg;

  localparam int NUM_IO_DEFAULT = 38;

  // Byte offsets within the 256-byte window.
  localparam logic [7:0] OFS_OUT_LO  = 8'h00;
  localparam logic [7:0] OFS_OUT_HI  = 8'h04;
  localparam logic [7:0] OFS_OEB_LO  = 8'h08;
  localparam logic [7:0] OFS_OEB_HI  = 8'h0C;
  localparam logic [7:0] OFS_IN_LO   = 8'h10;
  localparam logic [7:0] OFS_IN_HI   = 8'h14;
  localparam logic [7:0] OFS_EDGE_LO = 8'h18;
  localparam logic [7:0] OFS_EDGE_HI = 8'h1C;

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwpayload_gpio_if.sv
// ============================================================================
// Module  : fwpayload_gpio_if
// Purpose : Wishbone classic slave bus bundle for the GPIO block.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fwpayload_gpio_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

`default_nettype wire

// File: rtl/fwpayload_gpio_sync.sv
// ============================================================================
// Module  : fwpayload_gpio_sync
// Purpose : Two-flop pad synchronizer plus previous-value flop and
//           rising-edge detect on the synchronized value.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fwpayload_gpio_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Clearing to zero makes a pad that is already high at release look like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/fwpayload_gpio.sv
// ============================================================================
// Module  : fwpayload_gpio
// Purpose : Wishbone-mapped GPIO: output/enable registers, synchronized
//           inputs, sticky rising-edge flags and a level interrupt.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fwpayload_gpio
  import fwpayload_pkg::*;
#(
  parameter int          NUM_IO   = NUM_IO_DEFAULT,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  fwpayload_gpio_if.slave   wb,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              irq_o
);

  localparam logic [NUM_IO-1:0] HI_BITS = {{(NUM_IO-32){1'b1}}, 32'h0};

  logic [NUM_IO-1:0] out_q, out_d;
  logic [NUM_IO-1:0] oeb_q, oeb_d;
  logic [NUM_IO-1:0] edge_q, edge_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              irq_q, irq_d;

  logic [NUM_IO-1:0] w_sync, w_rise;
  logic [NUM_IO-1:0] w_lane_mask, w_lane_dat, w_lo_m, w_hi_m, w_clr;
  logic [31:0]       w_bm, w_rdata;
  logic [7:0]        w_ofs;
  logic              w_match, w_req, w_wr;
  logic              w_unused_adr;

  fwpayload_gpio_sync #(.WIDTH(NUM_IO)) u_sync (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .d_i    (io_in),
    .sync_o (w_sync),
    .rise_o (w_rise)
  );

  assign w_match      = (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign w_req        = wb.wbs_cyc_i & wb.wbs_stb_i & w_match & ~ack_q;
  assign w_wr         = w_req & wb.wbs_we_i;
  assign w_ofs        = {wb.wbs_adr_i[7:2], 2'b00};
  assign w_bm         = byte_mask(wb.wbs_sel_i);
  assign w_unused_adr = ^wb.wbs_adr_i[1:0];

  // Each pad bit maps to bus lane (bit mod 32) in both the LO and HI registers.
  for (genvar i = 0; i < NUM_IO; i++) begin : g_lane
    assign w_lane_mask[i] = w_bm[i % 32];
    assign w_lane_dat[i]  = wb.wbs_dat_i[i % 32];
  end

  assign w_lo_m = w_lane_mask & ~HI_BITS;
  assign w_hi_m = w_lane_mask & HI_BITS;

  always_comb begin
    w_rdata = '0;
    case (w_ofs)
      OFS_OUT_LO:  w_rdata = out_q[31:0];
      OFS_OUT_HI:  w_rdata = 32'(out_q[NUM_IO-1:32]);
      OFS_OEB_LO:  w_rdata = oeb_q[31:0];
      OFS_OEB_HI:  w_rdata = 32'(oeb_q[NUM_IO-1:32]);
      OFS_IN_LO:   w_rdata = w_sync[31:0];
      OFS_IN_HI:   w_rdata = 32'(w_sync[NUM_IO-1:32]);
      OFS_EDGE_LO: w_rdata = edge_q[31:0];
      OFS_EDGE_HI: w_rdata = 32'(edge_q[NUM_IO-1:32]);
      default:     w_rdata = '0;
    endcase
  end

  always_comb begin
    out_d = out_q;
    oeb_d = oeb_q;
    w_clr = '0;
    if (w_wr) begin
      case (w_ofs)
        OFS_OUT_LO:  out_d = (out_q & ~w_lo_m) | (w_lane_dat & w_lo_m);
        OFS_OUT_HI:  out_d = (out_q & ~w_hi_m) | (w_lane_dat & w_hi_m);
        OFS_OEB_LO:  oeb_d = (oeb_q & ~w_lo_m) | (w_lane_dat & w_lo_m);
        OFS_OEB_HI:  oeb_d = (oeb_q & ~w_hi_m) | (w_lane_dat & w_hi_m);
        OFS_EDGE_LO: w_clr = w_lane_dat & w_lo_m;
        OFS_EDGE_HI: w_clr = w_lane_dat & w_hi_m;
        default:     w_clr = '0;
      endcase
    end
    // A new edge in the same cycle as its clear keeps the flag set.
    edge_d = (edge_q & ~w_clr) | w_rise;
    ack_d  = w_req;
    dat_d  = (w_req && !wb.wbs_we_i) ? w_rdata : 32'h0;
    irq_d  = |edge_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_q  <= '0;
      oeb_q  <= '1;
      edge_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      oeb_q  <= oeb_d;
      edge_q <= edge_d;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      irq_q  <= irq_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign io_out       = out_q;
  assign io_oeb       = oeb_q;
  assign irq_o        = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_fwpayload_gpio.sv
// ============================================================================
// Module  : tb_fwpayload_gpio
// Purpose : Self-checking bench: directed scenarios plus randomized bus and
//           pad traffic compared each cycle against a behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fwpayload_gpio;
  import fwpayload_pkg::*;

  localparam int          NIO     = 38;
  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam logic [63:0] IO_MASK = (64'd1 << NIO) - 64'd1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NIO-1:0] io_in = '0;
  logic [NIO-1:0] io_out, io_oeb;
  logic           irq;

  fwpayload_gpio_if wb_if ();

  fwpayload_gpio #(.NUM_IO(NIO), .BASE_ADR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (wb_if),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state: register contents and the history of pad samples per edge.
  logic [63:0] m_out, m_oeb, m_edge;
  logic        m_ack, m_irq;
  logic [31:0] m_dat;
  logic [63:0] samp [$];
  int          last_rst = 0;

  function automatic logic [63:0] samp_at(input int n);
    if (n < 0 || n <= last_rst || n >= samp.size()) return 64'h0;
    return samp[n];
  endfunction

  function automatic logic [31:0] half(input logic [63:0] v, input logic hi);
    return hi ? v[63:32] : v[31:0];
  endfunction

  // Advance one clock edge: predict, clock, then compare all outputs.
  task automatic step();
    int          n = samp.size();
    logic [63:0] in_now = samp_at(n - 2);
    logic [63:0] rise   = in_now & ~samp_at(n - 3);
    logic        req, hi;
    logic [31:0] bm, rd;
    logic [63:0] wm, wd, clr;
    logic [63:0] n_out, n_oeb, n_edge;
    logic [7:0]  ofs;

    ofs = {wb_if.wbs_adr_i[7:2], 2'b00};
    hi  = ofs[2];
    req = wb_if.wbs_cyc_i && wb_if.wbs_stb_i && (wb_if.wbs_adr_i[31:8] == BASE[31:8]) && !m_ack;
    bm  = byte_mask(wb_if.wbs_sel_i);
    wm  = hi ? {bm, 32'h0} : {32'h0, bm};
    wd  = {wb_if.wbs_dat_i, wb_if.wbs_dat_i} & wm;
    rd  = 32'h0;
    if (ofs < 8'h08)      rd = half(m_out, hi);
    else if (ofs < 8'h10) rd = half(m_oeb, hi);
    else if (ofs < 8'h18) rd = half(in_now, hi);
    else if (ofs < 8'h20) rd = half(m_edge, hi);

    n_out = m_out;
    n_oeb = m_oeb;
    clr   = 64'h0;
    if (req && wb_if.wbs_we_i) begin
      if (ofs < 8'h08)      n_out = ((m_out & ~wm) | wd) & IO_MASK;
      else if (ofs < 8'h10) n_oeb = ((m_oeb & ~wm) | wd) & IO_MASK;
      else if (ofs >= 8'h18 && ofs < 8'h20) clr = wd;
    end
    n_edge = ((m_edge & ~clr) | rise) & IO_MASK;

    samp.push_back(64'(io_in));
    @(posedge clk);
    if (rst) begin
      last_rst = n;
      m_out = 64'h0; m_oeb = IO_MASK; m_edge = 64'h0;
      m_ack = 1'b0;  m_dat = 32'h0;   m_irq = 1'b0;
    end else begin
      m_irq  = |m_edge;
      m_out  = n_out;
      m_oeb  = n_oeb;
      m_edge = n_edge;
      m_ack  = req;
      m_dat  = (req && !wb_if.wbs_we_i) ? rd : 32'h0;
    end
    #1;
    check_eq("ack",    64'(wb_if.wbs_ack_o), 64'(m_ack));
    check_eq("dat_o",  64'(wb_if.wbs_dat_o), 64'(m_dat));
    check_eq("irq",    64'(irq),             64'(m_irq));
    check_eq("io_out", 64'(io_out),          m_out);
    check_eq("io_oeb", 64'(io_oeb),          m_oeb);
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    wb_if.wbs_cyc_i = 1'b1;
    wb_if.wbs_stb_i = 1'b1;
    wb_if.wbs_we_i  = we;
    wb_if.wbs_adr_i = adr;
    wb_if.wbs_dat_i = dat;
    wb_if.wbs_sel_i = sel;
  endtask

  task automatic release_bus();
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_stb_i = 1'b0;
    wb_if.wbs_we_i  = 1'b0;
  endtask

  task automatic wb_op(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
    acked = 1'b0;
    rdat  = 32'h0;
    drive(we, adr, dat, sel);
    for (int i = 0; i < 4 && !acked; i++) begin
      step();
      if (wb_if.wbs_ack_o) begin
        acked = 1'b1;
        rdat  = wb_if.wbs_dat_o;
      end
    end
    release_bus();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        ak;
    int          acks;
    logic [63:0] rnd;
    logic [31:0] adr;

    release_bus();
    wb_if.wbs_adr_i = 32'h0;
    wb_if.wbs_dat_i = 32'h0;
    wb_if.wbs_sel_i = 4'h0;

    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_eq("rst_oeb", 64'(io_oeb), IO_MASK);
    check_eq("rst_irq", 64'(irq), 64'h0);
    wb_op(1'b0, BASE | OFS_OEB_HI, 32'h0, 4'hF, rd, ak);
    check_eq("oeb_hi_ack", 64'(ak), 64'h1);
    check_eq("oeb_hi_rd",  64'(rd), 64'h3F);

    // Partial byte write
    wb_op(1'b1, BASE | OFS_OUT_LO, 32'hA5A5_A5A5, 4'b0011, rd, ak);
    check_eq("out_lo_pins", 64'(io_out[15:0]), 64'hA5A5);
    wb_op(1'b0, BASE | OFS_OUT_LO, 32'h0, 4'hF, rd, ak);
    check_eq("out_lo_rd", 64'(rd), 64'h0000_A5A5);

    // Edge on pad 35 and w1c clear
    io_in[35] = 1'b1;
    step(); step(); step();
    wb_op(1'b0, BASE | OFS_EDGE_HI, 32'h0, 4'hF, rd, ak);
    check_eq("edge_hi_rd",  64'(rd),  64'h8);
    check_eq("edge_hi_irq", 64'(irq), 64'h1);
    wb_op(1'b1, BASE | OFS_EDGE_HI, 32'h8, 4'hF, rd, ak);
    release_bus();
    step();
    check_eq("irq_clear", 64'(irq), 64'h0);
    wb_op(1'b0, BASE | OFS_EDGE_HI, 32'h0, 4'hF, rd, ak);
    check_eq("edge_hi_clr", 64'(rd), 64'h0);

    // Clear and new edge on the same bit in the same cycle
    io_in[0] = 1'b1;
    step(); step(); step();
    io_in[0] = 1'b0;
    step(); step(); step();
    io_in[0] = 1'b1;
    step(); step();
    wb_op(1'b1, BASE | OFS_EDGE_LO, 32'h1, 4'hF, rd, ak);
    wb_op(1'b0, BASE | OFS_EDGE_LO, 32'h0, 4'hF, rd, ak);
    check_eq("set_wins", 64'(rd), 64'h1);

    // Unmapped offset and out-of-window address
    wb_op(1'b0, BASE | 32'h40, 32'h0, 4'hF, rd, ak);
    check_eq("unmapped_ack", 64'(ak), 64'h1);
    check_eq("unmapped_rd",  64'(rd), 64'h0);
    acks = 0;
    drive(1'b0, BASE | 32'h100, 32'h0, 4'hF);
    for (int i = 0; i < 16; i++) begin
      step();
      if (wb_if.wbs_ack_o) acks++;
    end
    release_bus();
    check_eq("nomatch_acks", 64'(acks), 64'h0);

    // Held strobe acks every other cycle
    acks = 0;
    drive(1'b0, BASE | OFS_IN_LO, 32'h0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      step();
      if (wb_if.wbs_ack_o) acks++;
    end
    release_bus();
    check_eq("held_acks", 64'(acks), 64'h4);

    // Reset during a write strobe aborts the transfer
    drive(1'b1, BASE | OFS_OUT_LO, 32'hFFFF_FFFF, 4'hF);
    rst = 1'b1;
    step();
    check_eq("rst_abort_ack", 64'(wb_if.wbs_ack_o), 64'h0);
    rst = 1'b0;
    release_bus();
    wb_op(1'b0, BASE | OFS_OUT_LO, 32'h0, 4'hF, rd, ak);
    check_eq("rst_abort_out", 64'(rd), 64'h0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        rnd   = {32'($urandom), 32'($urandom)};
        io_in = rnd[NIO-1:0];
      end
      adr = BASE | (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) adr = adr ^ (32'h1 << $urandom_range(8, 31));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        drive(1'($urandom), adr, $urandom, 4'($urandom));
        for (int i = 0; i < 5; i++) step();
        release_bus();
      end else begin
        wb_op(1'($urandom), adr, $urandom, 4'($urandom), rd, ak);
      end
      for (int i = 0; i < $urandom_range(0, 2); i++) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
